// File: rtl/i2s_sample_tx_if.sv
// i2s_sample_tx_if: valid/ready sample handshake between a PCM source and the I2S transmitter
interface i2s_sample_tx_if #(
    parameter int SAMPLE_W = 24
);
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                sample_ready;
    modport master (output sample, output sample_valid, input sample_ready);
    modport slave (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: FIFO-buffered mono PCM to I2S serializer driven by codec-mastered SCLK/LRCLK
module i2s_sample_tx #(
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        en,
    i2s_sample_tx_if.slave              bus,
    input  logic                        sclk_in,
    input  logic                        lrclk_in,
    output logic                        sdout,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    output logic [7:0]                  underrun_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SAMPLE_W + 1);
    typedef enum logic [1:0] {IDLE, DELAY, SHIFT} state_t;
    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [SAMPLE_W-1:0] frame_sample, shreg, slot_word;
    logic [CW-1:0]       bit_cnt;
    logic                sclk_s1, sclk_s2, sclk_h, lr_s1, lr_s2, lr_prev;
    logic                sclk_fall, lr_edge, empty, push, pop, load, shift, pad, starve;

    assign bus.sample_ready = fifo_level != (AW+1)'(FIFO_DEPTH);
    assign empty            = fifo_level == '0;
    assign push             = bus.sample_valid & bus.sample_ready;
    assign sclk_fall        = sclk_h & ~sclk_s2;
    assign lr_edge          = lr_s2 != lr_prev;
    // Right slot replays the left word so each mono sample costs exactly one pop
    assign slot_word        = lr_s2 ? frame_sample : (pop ? mem[rd_ptr] : '0);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        starve  = 1'b0;
        shift   = 1'b0;
        pad     = 1'b0;
        if (sclk_fall) begin
            if (lr_edge) begin
                state_d = DELAY;
                load    = 1'b1;
                pop     = ~lr_s2 & en & ~empty;
                starve  = ~lr_s2 & en & empty;
            end else begin
                case (state_q)
                    DELAY: begin
                        state_d = SHIFT;
                        shift   = 1'b1;
                    end
                    SHIFT: begin
                        shift = bit_cnt < CW'(SAMPLE_W);
                        pad   = bit_cnt >= CW'(SAMPLE_W);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= bus.sample;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {sclk_h, sclk_s2, sclk_s1} <= '0;
            {lr_prev, lr_s2, lr_s1}    <= '0;
            state_q      <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            frame_sample <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            sdout        <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            {sclk_h, sclk_s2, sclk_s1} <= {sclk_s2, sclk_s1, sclk_in};
            {lr_s2, lr_s1}             <= {lr_s1, lrclk_in};
            if (sclk_fall) lr_prev <= lr_s2;
            state_q    <= state_d;
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
            if (load && !lr_s2) frame_sample <= slot_word;
            // sdout is left untouched on load: that is the I2S one-bit delay
            if (load) shreg <= slot_word;
            else if (shift) shreg <= {shreg[SAMPLE_W-2:0], 1'b0};
            if (shift) begin
                sdout   <= shreg[SAMPLE_W-1];
                bit_cnt <= (state_q == DELAY) ? CW'(1) : bit_cnt + CW'(1);
            end
            if (pad) sdout <= 1'b0;
            if (starve) begin
                underrun     <= 1'b1;
                underrun_cnt <= underrun_cnt + 8'(underrun_cnt != 8'hFF);
            end
        end
    end
endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: directed I2S framing, FIFO, underrun, reset and jitter checks
`timescale 1ns/1ps
module tb_i2s_sample_tx;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        en = 1'b1;
    logic        sclk_in = 1'b1;
    logic        lrclk_in = 1'b0;
    logic        sdout;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic [7:0]  underrun_cnt;
    int          n_asserts = 0;
    int          n_fail = 0;
    logic [31:0] bits;
    logic [23:0] t2v [4];
    logic [23:0] smp [64];

    i2s_sample_tx_if #(.SAMPLE_W(24)) bus ();

    i2s_sample_tx #(.SAMPLE_W(24), .FIFO_DEPTH(4)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .en(en),
        .bus(bus),
        .sclk_in(sclk_in),
        .lrclk_in(lrclk_in),
        .sdout(sdout),
        .fifo_level(fifo_level),
        .underrun(underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] v);
        @(negedge Clk);
        bus.sample = v;
        bus.sample_valid = 1'b1;
        @(negedge Clk);
        bus.sample_valid = 1'b0;
    endtask

    // One slot of n SCLK periods; the word clock changes with each falling edge,
    // sdout is captured at each rising edge (codec sample point), first bit in the MSB.
    task automatic slot(input logic lr, input int n, input int hmin, input int hmax, output logic [31:0] b);
        b = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            if (hmax > hmin) #($urandom_range(8, 1));
            sclk_in = 1'b0;
            lrclk_in = lr;
            repeat ($urandom_range(hmax, hmin)) @(negedge Clk);
            if (hmax > hmin) #($urandom_range(8, 1));
            sclk_in = 1'b1;
            b = {b[30:0], sdout};
            repeat ($urandom_range(hmax, hmin) - 1) @(negedge Clk);
        end
    endtask

    initial begin
        bus.sample = '0;
        bus.sample_valid = 1'b0;
        #2 Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_sdout", 32'(sdout), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(bus.sample_ready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_cnt", 32'(underrun_cnt), 32'd0);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        // T1: single sample framed into both slots
        push(24'hABCDEF);
        check("t1_level_push", 32'(fifo_level), 32'd1);
        slot(1'b1, 32, 4, 4, bits);
        check("t1_idle_slot", bits, 32'd0);
        slot(1'b0, 32, 4, 4, bits);
        check("t1_left", bits, 32'h55E6F780);
        check("t1_level_pop", 32'(fifo_level), 32'd0);
        slot(1'b1, 32, 4, 4, bits);
        check("t1_right", bits, 32'h55E6F780);

        // T2: fill FIFO, full backpressure, order preserved
        t2v = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        for (int i = 0; i < 4; i++) push(t2v[i]);
        check("t2_level_full", 32'(fifo_level), 32'd4);
        check("t2_ready_full", 32'(bus.sample_ready), 32'd0);
        @(negedge Clk);
        bus.sample = 24'h555555;
        bus.sample_valid = 1'b1;
        repeat (4) @(negedge Clk);
        check("t2_level_blocked", 32'(fifo_level), 32'd4);
        bus.sample_valid = 1'b0;
        slot(1'b0, 32, 4, 4, bits);
        check("t2_left0", bits, 32'h111111 << 7);
        check("t2_level_after_pop", 32'(fifo_level), 32'd3);
        check("t2_ready_after_pop", 32'(bus.sample_ready), 32'd1);
        push(24'h555555);
        check("t2_level_refill", 32'(fifo_level), 32'd4);
        slot(1'b1, 32, 4, 4, bits);
        check("t2_right0", bits, 32'h111111 << 7);
        t2v = '{24'h222222, 24'h333333, 24'h444444, 24'h555555};
        for (int i = 0; i < 4; i++) begin
            slot(1'b0, 32, 4, 4, bits);
            check("t2_left_seq", bits, 32'(t2v[i]) << 7);
            slot(1'b1, 32, 4, 4, bits);
            check("t2_right_seq", bits, 32'(t2v[i]) << 7);
        end
        check("t2_level_drained", 32'(fifo_level), 32'd0);
        check("t2_cnt_zero", 32'(underrun_cnt), 32'd0);

        // T3: starvation and saturation of the underrun counter
        for (int i = 0; i < 3; i++) begin
            slot(1'b0, 32, 4, 4, bits);
            check("t3_left_silent", bits, 32'd0);
            slot(1'b1, 32, 4, 4, bits);
        end
        check("t3_underrun", 32'(underrun), 32'd1);
        check("t3_cnt3", 32'(underrun_cnt), 32'd3);
        for (int i = 0; i < 252; i++) begin
            slot(1'b0, 1, 4, 4, bits);
            slot(1'b1, 1, 4, 4, bits);
        end
        check("t3_cnt255", 32'(underrun_cnt), 32'd255);
        for (int i = 0; i < 45; i++) begin
            slot(1'b0, 1, 4, 4, bits);
            slot(1'b1, 1, 4, 4, bits);
        end
        check("t3_cnt_sat", 32'(underrun_cnt), 32'd255);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("t3_rst_underrun", 32'(underrun), 32'd0);
        check("t3_rst_cnt", 32'(underrun_cnt), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        // T4: playback disabled holds FIFO contents and stays silent
        en = 1'b0;
        push(24'h0A0B0C);
        push(24'h123456);
        for (int i = 0; i < 5; i++) begin
            slot(1'b0, 32, 4, 4, bits);
            check("t4_left_silent", bits, 32'd0);
            slot(1'b1, 32, 4, 4, bits);
            check("t4_right_silent", bits, 32'd0);
        end
        check("t4_level_held", 32'(fifo_level), 32'd2);
        check("t4_no_underrun", 32'(underrun), 32'd0);
        en = 1'b1;
        slot(1'b0, 32, 4, 4, bits);
        check("t4_left_word0", bits, 32'h05058600);
        check("t4_level_pop", 32'(fifo_level), 32'd1);
        slot(1'b1, 32, 4, 4, bits);
        check("t4_right_word0", bits, 32'h05058600);

        // T5: reset in the middle of shifting 0x800001
        slot(1'b0, 32, 4, 4, bits);
        check("t5_left_word1", bits, 32'h091A2B00);
        slot(1'b1, 32, 4, 4, bits);
        push(24'h800001);
        push(24'h7FFFFF);
        slot(1'b0, 2, 4, 4, bits);
        check("t5_msb_out", bits, 32'd1);
        check("t5_sdout_high", 32'(sdout), 32'd1);
        check("t5_level_pre", 32'(fifo_level), 32'd1);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("t5_rst_sdout", 32'(sdout), 32'd0);
        check("t5_rst_level", 32'(fifo_level), 32'd0);
        check("t5_rst_ready", 32'(bus.sample_ready), 32'd1);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        slot(1'b0, 8, 4, 4, bits);
        check("t5_idle_after_rst", bits, 32'd0);
        push(24'h800001);
        slot(1'b1, 32, 4, 4, bits);
        check("t5_right_empty", bits, 32'd0);
        slot(1'b0, 32, 4, 4, bits);
        check("t5_left_resume", bits, 32'h40000080);
        slot(1'b1, 32, 4, 4, bits);
        check("t5_right_resume", bits, 32'h40000080);
        check("t5_no_underrun", 32'(underrun), 32'd0);

        // T6: jittered, phase-shifted SCLK with random samples, 26-bit slots
        for (int i = 0; i < 64; i++) smp[i] = 24'($urandom);
        push(smp[0]);
        push(smp[1]);
        for (int i = 0; i < 64; i++) begin
            slot(1'b0, 26, 4, 7, bits);
            check("t6_left", bits, 32'(smp[i]) << 1);
            slot(1'b1, 26, 4, 7, bits);
            check("t6_right", bits, 32'(smp[i]) << 1);
            if (i + 2 < 64) push(smp[i+2]);
        end
        check("t6_level_end", 32'(fifo_level), 32'd0);
        check("t6_no_underrun", 32'(underrun), 32'd0);
        check("t6_cnt_zero", 32'(underrun_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
